// File: rtl/tl_ram_slave_if.sv
// TileLink-UL A/D channel bundle between one requester and the RAM responder.
interface tl_ram_slave_if #(
    parameter int unsigned SRC_W = 4
);
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [63:0]      a_address;
    logic [7:0]       a_mask;
    logic [63:0]      a_data;
    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic [63:0]      d_data;
    logic             d_error;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
endinterface

// File: rtl/tl_ram_slave.sv
// TileLink-UL single-outstanding responder over a 64-bit synchronous RAM with
// programmable wait states between A acceptance and D valid.
module tl_ram_slave #(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned SRC_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    tl_ram_slave_if.slave  tl
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;

    logic             w_a_ready;
    logic             w_d_valid;
    logic             w_fire;
    logic             w_is_get;
    logic             w_is_put;
    logic             w_in_range;
    logic             w_err;
    logic [63:0]      w_offset;
    logic [AW-1:0]    w_idx;

    logic [63:0]      r_mem [DEPTH];

    logic [2:0]       r_d_opcode;
    logic [2:0]       r_d_size;
    logic [SRC_W-1:0] r_d_source;
    logic [63:0]      r_d_data;
    logic             r_d_error;

    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] lo);
        case (size)
            3'd0:    return 1'b0;
            3'd1:    return lo[0];
            3'd2:    return |lo[1:0];
            3'd3:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

    // BASE is word aligned, so the word index needs no borrow from the byte bits
    assign w_offset   = tl.a_address - BASE;
    assign w_in_range = (tl.a_address >= BASE) && (w_offset < SPAN);
    assign w_idx      = tl.a_address[3 +: AW] - BASE[3 +: AW];
    assign w_is_get   = (tl.a_opcode == 3'd4);
    assign w_is_put   = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1);
    assign w_err      = !w_in_range || (tl.a_size > 3'd3) ||
                        misaligned(tl.a_size, tl.a_address[2:0]) ||
                        !(w_is_get || w_is_put);
    assign w_fire     = tl.a_valid && w_a_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_fire) begin
                r_cnt <= 4'(LATENCY - 1);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  if (tl.d_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // a_ready is gated by rst so nothing is accepted or written while in reset
    always_comb begin
        w_a_ready = (r_state == S_IDLE) && !rst;
        w_d_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (w_fire && w_is_put && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (tl.a_mask[i]) r_mem[w_idx][8*i +: 8] <= tl.a_data[8*i +: 8];
            end
        end
    end

    // Response fields only change at acceptance, which keeps them stable under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_opcode <= 3'd0;
            r_d_size   <= 3'd0;
            r_d_source <= '0;
            r_d_data   <= 64'd0;
            r_d_error  <= 1'b0;
        end else if (w_fire) begin
            r_d_opcode <= w_is_get ? 3'd1 : 3'd0;
            r_d_size   <= tl.a_size;
            r_d_source <= tl.a_source;
            r_d_data   <= (w_is_get && !w_err) ? r_mem[w_idx] : 64'd0;
            r_d_error  <= w_err;
        end
    end

    assign tl.a_ready  = w_a_ready;
    assign tl.d_valid  = w_d_valid;
    assign tl.d_opcode = r_d_opcode;
    assign tl.d_size   = r_d_size;
    assign tl.d_source = r_d_source;
    assign tl.d_data   = r_d_data;
    assign tl.d_error  = r_d_error;
endmodule

// File: tb/tb_tl_ram_slave.sv
// Scoreboard bench: unit 0 is a zero-wait-state slave, unit 1 has three wait states.
module tb_tl_ram_slave;
    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [3:0]  src;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst3;
    logic        a_valid [2];
    logic        a_ready [2];
    logic [2:0]  a_opcode [2];
    logic [2:0]  a_size [2];
    logic [3:0]  a_source [2];
    logic [63:0] a_address [2];
    logic [7:0]  a_mask [2];
    logic [63:0] a_data [2];
    logic        d_valid [2];
    logic        d_ready [2];
    logic [2:0]  d_opcode [2];
    logic [2:0]  d_size [2];
    logic [3:0]  d_source [2];
    logic [63:0] d_data [2];
    logic        d_error [2];

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q3[$];
    exp_t m0;
    exp_t m3;

    always #5 clk = ~clk;

    tl_ram_slave_if #(.SRC_W(4)) bus0 ();
    tl_ram_slave_if #(.SRC_W(4)) bus3 ();

    assign bus0.a_valid   = a_valid[0];
    assign bus0.a_opcode  = a_opcode[0];
    assign bus0.a_size    = a_size[0];
    assign bus0.a_source  = a_source[0];
    assign bus0.a_address = a_address[0];
    assign bus0.a_mask    = a_mask[0];
    assign bus0.a_data    = a_data[0];
    assign bus0.d_ready   = d_ready[0];
    assign a_ready[0]     = bus0.a_ready;
    assign d_valid[0]     = bus0.d_valid;
    assign d_opcode[0]    = bus0.d_opcode;
    assign d_size[0]      = bus0.d_size;
    assign d_source[0]    = bus0.d_source;
    assign d_data[0]      = bus0.d_data;
    assign d_error[0]     = bus0.d_error;

    assign bus3.a_valid   = a_valid[1];
    assign bus3.a_opcode  = a_opcode[1];
    assign bus3.a_size    = a_size[1];
    assign bus3.a_source  = a_source[1];
    assign bus3.a_address = a_address[1];
    assign bus3.a_mask    = a_mask[1];
    assign bus3.a_data    = a_data[1];
    assign bus3.d_ready   = d_ready[1];
    assign a_ready[1]     = bus3.a_ready;
    assign d_valid[1]     = bus3.d_valid;
    assign d_opcode[1]    = bus3.d_opcode;
    assign d_size[1]      = bus3.d_size;
    assign d_source[1]    = bus3.d_source;
    assign d_data[1]      = bus3.d_data;
    assign d_error[1]     = bus3.d_error;

    tl_ram_slave #(.DEPTH(4096), .BASE(64'h0000_0000_8000_0000), .LATENCY(0), .SRC_W(4))
        u_dut0 (.clk(clk), .rst(rst0), .tl(bus0));
    tl_ram_slave #(.DEPTH(4096), .BASE(64'h0000_0000_8000_0000), .LATENCY(3), .SRC_W(4))
        u_dut3 (.clk(clk), .rst(rst3), .tl(bus3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input int u, input exp_t e);
        chk($sformatf("u%0d d_opcode", u), 64'(d_opcode[u]), 64'(e.op));
        chk($sformatf("u%0d d_size", u),   64'(d_size[u]),   64'(e.size));
        chk($sformatf("u%0d d_source", u), 64'(d_source[u]), 64'(e.src));
        chk($sformatf("u%0d d_data", u),   d_data[u],        e.data);
        chk($sformatf("u%0d d_error", u),  64'(d_error[u]),  64'(e.err));
    endtask

    always @(negedge clk) begin
        if (!rst0 && d_valid[0] && d_ready[0]) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL u0 unexpected response: got d_valid=1 expected none");
            end else begin
                m0 = q0.pop_front();
                cmp(0, m0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3 && d_valid[1] && d_ready[1]) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1 unexpected response: got d_valid=1 expected none");
            end else begin
                m3 = q3.pop_front();
                cmp(1, m3);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the D fire has completed.
    task automatic issue(input int u, input logic [2:0] op, input logic [2:0] size,
                         input logic [3:0] src, input logic [63:0] addr, input logic [7:0] mask,
                         input logic [63:0] data, input logic [2:0] eop, input logic [63:0] edata,
                         input logic eerr, input int bp);
        exp_t e;
        int   lat;
        int   n;
        e   = '{op: eop, size: size, src: src, data: edata, err: eerr};
        lat = (u == 0) ? 0 : 3;
        if (u == 0) q0.push_back(e); else q3.push_back(e);
        d_ready[u]   = (bp == 0);
        a_opcode[u]  = op;
        a_size[u]    = size;
        a_source[u]  = src;
        a_address[u] = addr;
        a_mask[u]    = mask;
        a_data[u]    = data;
        a_valid[u]   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_ready[u] && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("u%0d accept", u), 64'(a_ready[u]), 64'd1);
        @(posedge clk);
        #1 a_valid[u] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!d_valid[u] && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("u%0d d_latency", u), 64'(n), 64'(1 + lat));
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                chk($sformatf("u%0d bp d_valid", u),  64'(d_valid[u]),  64'd1);
                chk($sformatf("u%0d bp a_ready", u),  64'(a_ready[u]),  64'd0);
                chk($sformatf("u%0d bp d_data", u),   d_data[u],        edata);
                chk($sformatf("u%0d bp d_source", u), 64'(d_source[u]), 64'(src));
                if (i < bp - 1) @(negedge clk);
            end
            @(posedge clk);
            #1 d_ready[u] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("u%0d a_ready after D", u), 64'(a_ready[u]), 64'd1);
        chk($sformatf("u%0d d_valid after D", u), 64'(d_valid[u]), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            a_valid[u] = 1'b0; a_opcode[u] = 3'd0; a_size[u] = 3'd0; a_source[u] = 4'd0;
            a_address[u] = 64'd0; a_mask[u] = 8'd0; a_data[u] = 64'd0; d_ready[u] = 1'b1;
        end
        rst0 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d rst a_ready", u),  64'(a_ready[u]),  64'd0);
            chk($sformatf("u%0d rst d_valid", u),  64'(d_valid[u]),  64'd0);
            chk($sformatf("u%0d rst d_opcode", u), 64'(d_opcode[u]), 64'd0);
            chk($sformatf("u%0d rst d_data", u),   d_data[u],        64'd0);
            chk($sformatf("u%0d rst d_error", u),  64'(d_error[u]),  64'd0);
        end
        @(posedge clk);
        #1 rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        chk("u0 a_ready after rst", 64'(a_ready[0]), 64'd1);
        chk("u1 a_ready after rst", 64'(a_ready[1]), 64'd1);
        @(posedge clk);
        #1;

        // Zero-wait-state unit: writes, reads, partial writes and error cases
        issue(0, 3'd0, 3'd3, 4'd1, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 3'd0, 64'd0, 1'b0, 0);
        issue(0, 3'd4, 3'd3, 4'd2, 64'h8000_0010, 8'hFF, 64'd0, 3'd1, 64'h1122334455667788, 1'b0, 0);
        issue(0, 3'd1, 3'd3, 4'd3, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 3'd0, 64'd0, 1'b0, 0);
        issue(0, 3'd4, 3'd3, 4'd4, 64'h8000_0010, 8'hFF, 64'd0, 3'd1, 64'h11223344_BBBBBBBB, 1'b0, 0);
        issue(0, 3'd4, 3'd3, 4'd5, 64'h8000_8000, 8'hFF, 64'd0, 3'd1, 64'd0, 1'b1, 0);
        issue(0, 3'd0, 3'd3, 4'd6, 64'h8000_0000, 8'hFF, 64'hDEADBEEF_01234567, 3'd0, 64'd0, 1'b0, 0);
        issue(0, 3'd0, 3'd3, 4'd7, 64'h7FFF_FFF8, 8'hFF, 64'h0BAD0BAD_0BAD0BAD, 3'd0, 64'd0, 1'b1, 0);
        issue(0, 3'd4, 3'd3, 4'd8, 64'h8000_0000, 8'hFF, 64'd0, 3'd1, 64'hDEADBEEF_01234567, 1'b0, 0);
        issue(0, 3'd4, 3'd2, 4'd9, 64'h8000_0002, 8'h0F, 64'd0, 3'd1, 64'd0, 1'b1, 0);
        issue(0, 3'd6, 3'd3, 4'd5, 64'h8000_0000, 8'hFF, 64'h1, 3'd0, 64'd0, 1'b1, 0);
        issue(0, 3'd4, 3'd4, 4'd3, 64'h8000_0000, 8'hFF, 64'd0, 3'd1, 64'd0, 1'b1, 0);
        issue(0, 3'd0, 3'd3, 4'd1, 64'h8000_7FF8, 8'hFF, 64'hCAFEF00D_CAFEF00D, 3'd0, 64'd0, 1'b0, 0);
        issue(0, 3'd4, 3'd3, 4'd2, 64'h8000_7FF8, 8'hFF, 64'd0, 3'd1, 64'hCAFEF00D_CAFEF00D, 1'b0, 0);
        issue(0, 3'd0, 3'd0, 4'd6, 64'h8000_0010, 8'hF0, 64'h55667788_00000000, 3'd0, 64'd0, 1'b0, 0);
        issue(0, 3'd4, 3'd3, 4'd7, 64'h8000_0010, 8'hFF, 64'd0, 3'd1, 64'h55667788_BBBBBBBB, 1'b0, 0);

        // Three-wait-state unit: latency, backpressure and source echo
        issue(1, 3'd0, 3'd3, 4'd3, 64'h8000_0000, 8'hFF, 64'h01234567_89ABCDEF, 3'd0, 64'd0, 1'b0, 0);
        issue(1, 3'd4, 3'd3, 4'hA, 64'h8000_0000, 8'hFF, 64'd0, 3'd1, 64'h01234567_89ABCDEF, 1'b0, 5);

        // Reset while waiting: the pending Get is dropped, RAM keeps its contents
        d_ready[1]   = 1'b0;
        a_opcode[1]  = 3'd4; a_size[1] = 3'd3; a_source[1] = 4'd2;
        a_address[1] = 64'h8000_0000; a_mask[1] = 8'hFF; a_valid[1] = 1'b1;
        @(negedge clk);
        chk("u1 pre-rst accept", 64'(a_ready[1]), 64'd1);
        @(posedge clk);
        #1 a_valid[1] = 1'b0; rst3 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("u1 mid-rst d_valid", 64'(d_valid[1]), 64'd0);
        chk("u1 mid-rst a_ready", 64'(a_ready[1]), 64'd0);
        chk("u1 mid-rst d_data",  d_data[1],       64'd0);
        @(posedge clk);
        #1 rst3 = 1'b0; d_ready[1] = 1'b1;
        @(negedge clk);
        chk("u1 a_ready after mid-rst", 64'(a_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        issue(1, 3'd4, 3'd3, 4'd4, 64'h8000_0000, 8'hFF, 64'd0, 3'd1, 64'h01234567_89ABCDEF, 1'b0, 0);

        repeat (2) @(posedge clk);
        chk("u0 scoreboard drained", 64'(q0.size()), 64'd0);
        chk("u1 scoreboard drained", 64'(q3.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
